// File: rtl/alu_unit_pkg.sv
// Shared opcode enum, widths and helpers for the ALU execution stage.
// Imported by alu_core and alu_unit.
package alu_unit_pkg;

   localparam int XLEN  = 32;
   localparam int TAG_W = 4;
   localparam int OP_W  = 6;

   typedef enum logic [OP_W-1:0] {
      OP_NOP   = 6'd0,
      OP_LUI   = 6'd1,
      OP_AUIPC = 6'd2,
      OP_JAL   = 6'd3,
      OP_JALR  = 6'd4,
      OP_BEQ   = 6'd5,
      OP_BNE   = 6'd6,
      OP_BLT   = 6'd7,
      OP_BGE   = 6'd8,
      OP_BLTU  = 6'd9,
      OP_BGEU  = 6'd10,
      OP_ADD   = 6'd11,
      OP_SUB   = 6'd12,
      OP_SLL   = 6'd13,
      OP_SLT   = 6'd14,
      OP_SLTU  = 6'd15,
      OP_XOR   = 6'd16,
      OP_SRL   = 6'd17,
      OP_SRA   = 6'd18,
      OP_OR    = 6'd19,
      OP_AND   = 6'd20,
      OP_ADDI  = 6'd21,
      OP_SLTI  = 6'd22,
      OP_SLTIU = 6'd23,
      OP_XORI  = 6'd24,
      OP_ORI   = 6'd25,
      OP_ANDI  = 6'd26,
      OP_SLLI  = 6'd27,
      OP_SRLI  = 6'd28,
      OP_SRAI  = 6'd29
   } openum_e;

   // Conditional branches occupy one contiguous range of the enum.
   function automatic logic is_branch(input logic [OP_W-1:0] op);
      return (op >= OP_BEQ) && (op <= OP_BGEU);
   endfunction

endpackage

// File: rtl/alu_unit_core.sv
// Combinational ALU: computes rd value, next pc and taken flag for one op.
// Ports: op, v1, v2, imm, pc in; value, target_pc, is_jump out.
module alu_core
   import alu_unit_pkg::*;
#(
   parameter int DATA_W = XLEN
) (
   input  logic [OP_W-1:0]   op,
   input  logic [DATA_W-1:0] v1,
   input  logic [DATA_W-1:0] v2,
   input  logic [DATA_W-1:0] imm,
   input  logic [DATA_W-1:0] pc,
   output logic [DATA_W-1:0] value,
   output logic [DATA_W-1:0] target_pc,
   output logic              is_jump
);

   logic [DATA_W-1:0] pc4;
   logic [DATA_W-1:0] pc_imm;
   logic [DATA_W-1:0] v1_imm;
   logic              lt_s;
   logic              lt_u;
   logic              lt_si;
   logic              lt_ui;
   logic              eq;
   logic              taken;

   assign pc4    = pc + DATA_W'(4);
   assign pc_imm = pc + imm;
   assign v1_imm = v1 + imm;
   assign lt_s   = $signed(v1) < $signed(v2);
   assign lt_u   = v1 < v2;
   assign lt_si  = $signed(v1) < $signed(imm);
   assign lt_ui  = v1 < imm;
   assign eq     = v1 == v2;

   always_comb begin
      value     = '0;
      taken     = 1'b0;
      target_pc = pc4;
      case (op)
         OP_LUI:   value = imm;
         OP_AUIPC: value = pc_imm;
         OP_JAL: begin
            value     = pc4;
            taken     = 1'b1;
            target_pc = pc_imm;
         end
         OP_JALR: begin
            value     = pc4;
            taken     = 1'b1;
            target_pc = {v1_imm[DATA_W-1:1], 1'b0};
         end
         OP_BEQ:   taken = eq;
         OP_BNE:   taken = !eq;
         OP_BLT:   taken = lt_s;
         OP_BGE:   taken = !lt_s;
         OP_BLTU:  taken = lt_u;
         OP_BGEU:  taken = !lt_u;
         OP_ADD:   value = v1 + v2;
         OP_SUB:   value = v1 - v2;
         OP_SLL:   value = v1 << v2[4:0];
         OP_SLT:   value = DATA_W'(lt_s);
         OP_SLTU:  value = DATA_W'(lt_u);
         OP_XOR:   value = v1 ^ v2;
         OP_SRL:   value = v1 >> v2[4:0];
         OP_SRA:   value = $unsigned($signed(v1) >>> v2[4:0]);
         OP_OR:    value = v1 | v2;
         OP_AND:   value = v1 & v2;
         OP_ADDI:  value = v1_imm;
         OP_SLTI:  value = DATA_W'(lt_si);
         OP_SLTIU: value = DATA_W'(lt_ui);
         OP_XORI:  value = v1 ^ imm;
         OP_ORI:   value = v1 | imm;
         OP_ANDI:  value = v1 & imm;
         OP_SLLI:  value = v1 << imm[4:0];
         OP_SRLI:  value = v1 >> imm[4:0];
         OP_SRAI:  value = $unsigned($signed(v1) >>> imm[4:0]);
         default:  value = '0;
      endcase
      // Taken branches redirect; untaken ones fall through to pc+4.
      if (is_branch(op) && taken) begin
         target_pc = pc_imm;
      end
   end

   assign is_jump = taken;

endmodule

// File: rtl/alu_unit.sv
// ALU execution stage: computes one issued op per cycle and holds the result
// in an output slot plus one skid slot until the shared CDB grants it.
// Ports: clk/rst/rdy, RS issue bus (*_from_rs, ready_to_rs), flush,
// cdb_grant in, cdb_* result out (driven straight from the output slot).
module alu_unit
   import alu_unit_pkg::*;
#(
   parameter int DATA_W   = XLEN,
   parameter int ROB_ID_W = TAG_W,
   parameter int OPENUM_W = OP_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rdy,
   input  logic                valid_from_rs,
   input  logic [OPENUM_W-1:0] openum_from_rs,
   input  logic [DATA_W-1:0]   V1_from_rs,
   input  logic [DATA_W-1:0]   V2_from_rs,
   input  logic [DATA_W-1:0]   imm_from_rs,
   input  logic [DATA_W-1:0]   pc_from_rs,
   input  logic [ROB_ID_W-1:0] rob_id_from_rs,
   output logic                ready_to_rs,
   input  logic                flush,
   input  logic                cdb_grant,
   output logic                cdb_valid,
   output logic [ROB_ID_W-1:0] cdb_rob_id,
   output logic [DATA_W-1:0]   cdb_value,
   output logic [DATA_W-1:0]   cdb_target_pc,
   output logic                cdb_is_jump
);

   logic [DATA_W-1:0]   n_value;
   logic [DATA_W-1:0]   n_target;
   logic                n_jump;

   logic                o_valid;
   logic [ROB_ID_W-1:0] o_rob;
   logic [DATA_W-1:0]   o_value;
   logic [DATA_W-1:0]   o_target;
   logic                o_jump;

   logic                s_valid;
   logic [ROB_ID_W-1:0] s_rob;
   logic [DATA_W-1:0]   s_value;
   logic [DATA_W-1:0]   s_target;
   logic                s_jump;

   logic                accept;
   logic                drain;

   alu_core #(
      .DATA_W (DATA_W)
   ) u_core (
      .op        (openum_from_rs),
      .v1        (V1_from_rs),
      .v2        (V2_from_rs),
      .imm       (imm_from_rs),
      .pc        (pc_from_rs),
      .value     (n_value),
      .target_pc (n_target),
      .is_jump   (n_jump)
   );

   // Readiness depends only on the skid slot so RS never sees a
   // combinational path from the CDB arbiter.
   assign ready_to_rs = !s_valid;
   assign accept = rdy & valid_from_rs & ready_to_rs & !flush;
   assign drain  = rdy & o_valid & cdb_grant;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_valid  <= 1'b0;
         o_rob    <= '0;
         o_value  <= '0;
         o_target <= '0;
         o_jump   <= 1'b0;
         s_valid  <= 1'b0;
         s_rob    <= '0;
         s_value  <= '0;
         s_target <= '0;
         s_jump   <= 1'b0;
      end else if (rdy) begin
         if (flush) begin
            o_valid <= 1'b0;
            s_valid <= 1'b0;
         end else if (drain) begin
            if (s_valid) begin
               o_valid  <= 1'b1;
               o_rob    <= s_rob;
               o_value  <= s_value;
               o_target <= s_target;
               o_jump   <= s_jump;
               s_valid  <= 1'b0;
            end else if (accept) begin
               o_valid  <= 1'b1;
               o_rob    <= rob_id_from_rs;
               o_value  <= n_value;
               o_target <= n_target;
               o_jump   <= n_jump;
            end else begin
               o_valid  <= 1'b0;
            end
         end else if (accept) begin
            if (!o_valid) begin
               o_valid  <= 1'b1;
               o_rob    <= rob_id_from_rs;
               o_value  <= n_value;
               o_target <= n_target;
               o_jump   <= n_jump;
            end else begin
               s_valid  <= 1'b1;
               s_rob    <= rob_id_from_rs;
               s_value  <= n_value;
               s_target <= n_target;
               s_jump   <= n_jump;
            end
         end
      end
   end

   assign cdb_valid     = o_valid;
   assign cdb_rob_id    = o_rob;
   assign cdb_value     = o_value;
   assign cdb_target_pc = o_target;
   assign cdb_is_jump   = o_jump;

endmodule

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit: directed ops push expected CDB payloads,
// a negedge monitor pops and compares on every CDB drain.
module tb_alu_unit;
   import alu_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        valid_from_rs;
   logic [5:0]  openum_from_rs;
   logic [31:0] V1_from_rs;
   logic [31:0] V2_from_rs;
   logic [31:0] imm_from_rs;
   logic [31:0] pc_from_rs;
   logic [3:0]  rob_id_from_rs;
   logic        ready_to_rs;
   logic        flush;
   logic        cdb_grant;
   logic        cdb_valid;
   logic [3:0]  cdb_rob_id;
   logic [31:0] cdb_value;
   logic [31:0] cdb_target_pc;
   logic        cdb_is_jump;

   typedef struct {
      logic [3:0]  id;
      logic [31:0] value;
      logic [31:0] target;
      logic        jump;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   alu_unit dut (
      .clk            (clk),
      .rst            (rst),
      .rdy            (rdy),
      .valid_from_rs  (valid_from_rs),
      .openum_from_rs (openum_from_rs),
      .V1_from_rs     (V1_from_rs),
      .V2_from_rs     (V2_from_rs),
      .imm_from_rs    (imm_from_rs),
      .pc_from_rs     (pc_from_rs),
      .rob_id_from_rs (rob_id_from_rs),
      .ready_to_rs    (ready_to_rs),
      .flush          (flush),
      .cdb_grant      (cdb_grant),
      .cdb_valid      (cdb_valid),
      .cdb_rob_id     (cdb_rob_id),
      .cdb_value      (cdb_value),
      .cdb_target_pc  (cdb_target_pc),
      .cdb_is_jump    (cdb_is_jump)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: flush/reset discard pending results; a drain pops one.
   always @(negedge clk) begin
      if (rst || (rdy && flush)) begin
         sb.delete();
      end else if (rdy && cdb_valid && cdb_grant) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_cdb: got id %h value %h, none expected",
                     cdb_rob_id, cdb_value);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (cdb_rob_id !== e.id || cdb_value !== e.value ||
                cdb_target_pc !== e.target || cdb_is_jump !== e.jump) begin
               miscompares++;
               $display("FAIL cdb_id%0h: got %h/%h/%h/%b expected %h/%h/%h/%b",
                        e.id, cdb_rob_id, cdb_value, cdb_target_pc,
                        cdb_is_jump, e.id, e.value, e.target, e.jump);
            end
         end
      end
   end

   task automatic issue(input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] im,
                        input logic [31:0] p, input logic [3:0] id,
                        input logic [31:0] ev, input logic [31:0] et,
                        input logic ej);
      exp_t e;
      int n = 0;
      while (!ready_to_rs && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!ready_to_rs) begin
         vectors++;
         miscompares++;
         $display("FAIL issue_timeout: got ready 0 expected 1");
      end else begin
         openum_from_rs = op;
         V1_from_rs     = a;
         V2_from_rs     = b;
         imm_from_rs    = im;
         pc_from_rs     = p;
         rob_id_from_rs = id;
         valid_from_rs  = 1'b1;
         e.id = id;
         e.value = ev;
         e.target = et;
         e.jump = ej;
         sb.push_back(e);
         @(posedge clk);
         #1;
         valid_from_rs = 1'b0;
      end
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      rdy = 1'b1;
      flush = 1'b0;
      cdb_grant = 1'b0;
      valid_from_rs = 1'b0;
      openum_from_rs = '0;
      V1_from_rs = '0;
      V2_from_rs = '0;
      imm_from_rs = '0;
      pc_from_rs = '0;
      rob_id_from_rs = '0;
      #12;
      chk("rst_valid", 32'(cdb_valid), 32'd0);
      chk("rst_ready", 32'(ready_to_rs), 32'd1);
      chk("rst_value", cdb_value, 32'd0);
      chk("rst_target", cdb_target_pc, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Single op latency
      cdb_grant = 1'b1;
      issue(OP_ADDI, 32'd5, 32'd0, 32'hFFFFFFF9, 32'h0, 4'd1,
            32'hFFFFFFFE, 32'h4, 1'b0);
      chk("lat_valid", 32'(cdb_valid), 32'd1);
      chk("lat_value", cdb_value, 32'hFFFFFFFE);
      chk("lat_id", 32'(cdb_rob_id), 32'd1);
      @(posedge clk);
      #1;
      chk("lat_empty", 32'(cdb_valid), 32'd0);

      // Back-to-back directed vectors
      issue(OP_BLT, 32'hFFFFFFFF, 32'd1, 32'h20, 32'h100, 4'd2,
            32'h0, 32'h120, 1'b1);
      issue(OP_BLTU, 32'hFFFFFFFF, 32'd1, 32'h20, 32'h100, 4'd3,
            32'h0, 32'h104, 1'b0);
      issue(OP_JALR, 32'h203, 32'd0, 32'd4, 32'h40, 4'd4,
            32'h44, 32'h206, 1'b1);
      issue(OP_LUI, 32'd0, 32'd0, 32'h12345000, 32'h8, 4'd5,
            32'h12345000, 32'hC, 1'b0);
      issue(OP_AUIPC, 32'd0, 32'd0, 32'h2000, 32'h1000, 4'd6,
            32'h3000, 32'h1004, 1'b0);
      issue(OP_SUB, 32'd3, 32'd5, 32'd0, 32'h0, 4'd7,
            32'hFFFFFFFE, 32'h4, 1'b0);
      issue(OP_SRA, 32'h80000000, 32'h24, 32'd0, 32'h0, 4'd8,
            32'hF8000000, 32'h4, 1'b0);
      issue(OP_SRLI, 32'h80000000, 32'd0, 32'd4, 32'h0, 4'd9,
            32'h08000000, 32'h4, 1'b0);
      issue(OP_SLT, 32'hFFFFFFFF, 32'd0, 32'd0, 32'h0, 4'd10,
            32'h1, 32'h4, 1'b0);
      issue(OP_SLTU, 32'hFFFFFFFF, 32'd0, 32'd0, 32'h0, 4'd11,
            32'h0, 32'h4, 1'b0);
      issue(OP_JAL, 32'd0, 32'd0, 32'hFFFFFFF0, 32'h200, 4'd12,
            32'h204, 32'h1F0, 1'b1);
      issue(OP_BEQ, 32'd7, 32'd7, 32'd8, 32'h300, 4'd13,
            32'h0, 32'h308, 1'b1);
      issue(OP_BNE, 32'd7, 32'd7, 32'd8, 32'h300, 4'd14,
            32'h0, 32'h304, 1'b0);
      issue(OP_AND, 32'hF0F0, 32'hFF00, 32'd0, 32'h0, 4'd15,
            32'hF000, 32'h4, 1'b0);
      issue(6'h3F, 32'd9, 32'd9, 32'd9, 32'h10, 4'd0,
            32'h0, 32'h14, 1'b0);
      issue(OP_SLL, 32'd1, 32'd33, 32'd0, 32'h0, 4'd1,
            32'h2, 32'h4, 1'b0);
      issue(OP_BGE, 32'hFFFFFFFF, 32'd1, 32'h40, 32'h500, 4'd2,
            32'h0, 32'h504, 1'b0);
      issue(OP_BGEU, 32'hFFFFFFFF, 32'd1, 32'h40, 32'h500, 4'd3,
            32'h0, 32'h540, 1'b1);
      wait_drain();

      // Stall: fill O and S, third op waits in RS
      cdb_grant = 1'b0;
      issue(OP_ADD, 32'd10, 32'd20, 32'd0, 32'h0, 4'd3,
            32'd30, 32'h4, 1'b0);
      issue(OP_XORI, 32'hFF, 32'd0, 32'h0F, 32'h0, 4'd4,
            32'hF0, 32'h4, 1'b0);
      chk("stall_ready", 32'(ready_to_rs), 32'd0);
      fork
         issue(OP_ORI, 32'h100, 32'd0, 32'h1, 32'h0, 4'd5,
               32'h101, 32'h4, 1'b0);
      join_none
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("hold_id", 32'(cdb_rob_id), 32'd3);
         chk("hold_value", cdb_value, 32'd30);
      end
      cdb_grant = 1'b1;
      wait_drain();

      // Flush with O and S full and an op presented
      cdb_grant = 1'b0;
      issue(OP_ADD, 32'd1, 32'd1, 32'd0, 32'h0, 4'd5,
            32'd2, 32'h4, 1'b0);
      issue(OP_ADD, 32'd2, 32'd2, 32'd0, 32'h0, 4'd6,
            32'd4, 32'h4, 1'b0);
      openum_from_rs = OP_ADD;
      rob_id_from_rs = 4'd7;
      valid_from_rs = 1'b1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      valid_from_rs = 1'b0;
      flush = 1'b0;
      chk("flush_valid", 32'(cdb_valid), 32'd0);
      chk("flush_ready", 32'(ready_to_rs), 32'd1);
      cdb_grant = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("flush_quiet", 32'(cdb_valid), 32'd0);

      // rdy=0 freezes state and ignores grant/issue
      cdb_grant = 1'b0;
      issue(OP_ADD, 32'd2, 32'd3, 32'd0, 32'h0, 4'd8,
            32'd5, 32'h4, 1'b0);
      rdy = 1'b0;
      cdb_grant = 1'b1;
      openum_from_rs = OP_ADD;
      rob_id_from_rs = 4'd9;
      valid_from_rs = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("frz_valid", 32'(cdb_valid), 32'd1);
      chk("frz_id", 32'(cdb_rob_id), 32'd8);
      chk("frz_ready", 32'(ready_to_rs), 32'd1);
      valid_from_rs = 1'b0;
      rdy = 1'b1;
      wait_drain();
      @(posedge clk);
      #1;
      chk("frz_after", 32'(cdb_valid), 32'd0);

      // Asynchronous reset mid-stall
      cdb_grant = 1'b0;
      issue(OP_ADD, 32'd4, 32'd4, 32'd0, 32'h0, 4'd10,
            32'd8, 32'h4, 1'b0);
      issue(OP_ADD, 32'd6, 32'd6, 32'd0, 32'h0, 4'd11,
            32'd12, 32'h4, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_valid", 32'(cdb_valid), 32'd0);
      chk("arst_ready", 32'(ready_to_rs), 32'd1);
      chk("arst_value", cdb_value, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      cdb_grant = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("arst_quiet", 32'(cdb_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
